// File: rtl/pipe_skid_reg_if.sv
// Single-direction valid/ready/data link between pipeline stages.
// The DUT takes one instance as its upstream port (slave) and one as its downstream port (master).
interface pipe_skid_reg_if #(
    parameter int DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a 2-entry skid buffer, synchronous flush,
// occupancy reporting and a saturating stall counter; in_ready comes straight from a flop.
module pipe_skid_reg #(
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = {DATA_W{1'b0}},
    parameter int                CNT_W       = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    pipe_skid_reg_if.slave         up_if,
    pipe_skid_reg_if.master        dn_if,
    output logic [1:0]             occupancy_o,
    output logic [CNT_W-1:0]       stall_cnt_o
);

    // State is the pair {skid valid, main valid}; 2'b10 is unreachable.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_FULL  = 2'b01;
    localparam logic [1:0] ST_SKID  = 2'b11;

    localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};

    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              main_vld_q, main_vld_d;
    logic              skid_vld_q, skid_vld_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic [1:0] state_s;
    logic       in_ready_s;
    logic       acc_s;
    logic       snd_s;

    assign state_s    = {skid_vld_q, main_vld_q};
    assign in_ready_s = ~skid_vld_q;
    assign acc_s      = up_if.valid & in_ready_s;
    assign snd_s      = main_vld_q & dn_if.ready;

    assign up_if.ready = in_ready_s;
    assign dn_if.valid = main_vld_q;
    assign dn_if.data  = main_q;
    assign occupancy_o = {skid_vld_q, main_vld_q & ~skid_vld_q};
    assign stall_cnt_o = stall_q;

    // Next-state logic for the main/skid storage and their valid bits.
    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (flush_i) begin
            main_d     = BUBBLE_DATA;
            skid_d     = BUBBLE_DATA;
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else begin
            case (state_s)
                ST_EMPTY: begin
                    if (acc_s) begin
                        main_d     = up_if.data;
                        main_vld_d = 1'b1;
                    end else begin
                        main_d     = main_q;
                        main_vld_d = main_vld_q;
                    end
                end
                ST_FULL: begin
                    if (acc_s && snd_s) begin
                        main_d = up_if.data;
                    end else if (acc_s) begin
                        skid_d     = up_if.data;
                        skid_vld_d = 1'b1;
                    end else if (snd_s) begin
                        main_d     = BUBBLE_DATA;
                        main_vld_d = 1'b0;
                    end else begin
                        main_d = main_q;
                    end
                end
                ST_SKID: begin
                    if (snd_s) begin
                        main_d     = skid_q;
                        skid_d     = BUBBLE_DATA;
                        skid_vld_d = 1'b0;
                    end else begin
                        main_d = main_q;
                    end
                end
                default: begin
                    main_d     = BUBBLE_DATA;
                    skid_d     = BUBBLE_DATA;
                    main_vld_d = 1'b0;
                    skid_vld_d = 1'b0;
                end
            endcase
        end
    end

    // Stall counter saturates and ignores flushed cycles.
    always_comb begin
        if (main_vld_q && !dn_if.ready && !flush_i && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + CNT_W'(1);
        end else begin
            stall_d = stall_q;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            main_q     <= BUBBLE_DATA;
            skid_q     <= BUBBLE_DATA;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            stall_q    <= {CNT_W{1'b0}};
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            stall_q    <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: a queue scoreboard tracks accepted beats and a
// negedge monitor checks every delivered beat; status outputs are checked against hand values.
module tb_pipe_skid_reg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 3;

    logic clk;
    logic rst_n;
    logic flush;
    logic [1:0]       occ;
    logic [CNT_W-1:0] stall;

    pipe_skid_reg_if #(.DATA_W(DATA_W)) up_if ();
    pipe_skid_reg_if #(.DATA_W(DATA_W)) dn_if ();

    pipe_skid_reg #(
        .DATA_W     (DATA_W),
        .BUBBLE_DATA({DATA_W{1'b0}}),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .flush_i    (flush),
        .up_if      (up_if),
        .dn_if      (dn_if),
        .occupancy_o(occ),
        .stall_cnt_o(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int pop_cnt   = 0;
    logic [DATA_W-1:0] sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag, input logic ov, input logic [31:0] od,
                                input logic ir, input logic [1:0] oc, input logic [31:0] sc);
        check({tag, " out_valid"}, {31'd0, dn_if.valid}, {31'd0, ov});
        check({tag, " out_data"},  dn_if.data, od);
        check({tag, " in_ready"},  {31'd0, up_if.ready}, {31'd0, ir});
        check({tag, " occupancy"}, {30'd0, occ}, {30'd0, oc});
        check({tag, " stall_cnt"}, {29'd0, stall}, sc);
    endtask

    // Scoreboard producer: record every beat the DUT accepts at the coming edge.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            sb_q.delete();
        end else if (up_if.valid && up_if.ready) begin
            sb_q.push_back(up_if.data);
        end
    end

    // Monitor: compare each beat leaving the stage and the bubble value when idle.
    always @(negedge clk) begin
        if (rst_n && !flush) begin
            if (dn_if.valid && dn_if.ready) begin
                pop_cnt++;
                if (sb_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL mon_unexpected: got 0x%0h expected no beat", dn_if.data);
                end else begin
                    check("mon_beat", dn_if.data, sb_q.pop_front());
                end
            end else if (!dn_if.valid) begin
                check("mon_bubble", dn_if.data, 32'h0);
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        up_if.valid = 1'b0;
        up_if.data  = 32'h0;
        dn_if.ready = 1'b1;
        tick(); tick();
        check_status("reset", 1'b0, 32'h0, 1'b1, 2'd0, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            tick();
            check_status("idle", 1'b0, 32'h0, 1'b1, 2'd0, 32'd0);
        end

        // Streaming at full throughput.
        up_if.valid = 1'b1;
        up_if.data = 32'h100; tick(); check_status("stream0", 1'b1, 32'h100, 1'b1, 2'd1, 32'd0);
        up_if.data = 32'h104; tick(); check_status("stream1", 1'b1, 32'h104, 1'b1, 2'd1, 32'd0);
        up_if.data = 32'h108; tick(); check_status("stream2", 1'b1, 32'h108, 1'b1, 2'd1, 32'd0);
        up_if.valid = 1'b0; up_if.data = 32'hDEAD_BEEF;
        tick(); check_status("stream_end", 1'b0, 32'h0, 1'b1, 2'd0, 32'd0);

        // Backpressure fills the skid entry.
        dn_if.ready = 1'b0;
        up_if.valid = 1'b1;
        up_if.data = 32'hA; tick(); check_status("bp_a", 1'b1, 32'hA, 1'b1, 2'd1, 32'd0);
        up_if.data = 32'hB; tick(); check_status("bp_b", 1'b1, 32'hA, 1'b0, 2'd2, 32'd1);
        up_if.valid = 1'b0;
        tick(); check_status("bp_hold", 1'b1, 32'hA, 1'b0, 2'd2, 32'd2);
        dn_if.ready = 1'b1;
        tick(); check_status("bp_drain_a", 1'b1, 32'hB, 1'b1, 2'd1, 32'd2);
        tick(); check_status("bp_drain_b", 1'b0, 32'h0, 1'b1, 2'd0, 32'd2);

        // Flush while SKID with a beat offered.
        dn_if.ready = 1'b0;
        up_if.valid = 1'b1;
        up_if.data = 32'hA; tick();
        up_if.data = 32'hB; tick(); check_status("fl_pre", 1'b1, 32'hA, 1'b0, 2'd2, 32'd3);
        up_if.data = 32'hC; flush = 1'b1;
        tick(); check_status("fl_post", 1'b0, 32'h0, 1'b1, 2'd0, 32'd3);
        flush = 1'b0; up_if.valid = 1'b0; dn_if.ready = 1'b1;
        tick(); check_status("fl_idle", 1'b0, 32'h0, 1'b1, 2'd0, 32'd3);

        // Stall counter saturation.
        dn_if.ready = 1'b0;
        up_if.valid = 1'b1; up_if.data = 32'h77;
        tick();
        up_if.valid = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check("sat_stall", {29'd0, stall}, (3 + i > 7) ? 32'd7 : 32'(3 + i));
        end

        // Asynchronous reset while two beats are held.
        up_if.valid = 1'b1; up_if.data = 32'h88;
        tick(); check_status("ar_pre", 1'b1, 32'h77, 1'b0, 2'd2, 32'd7);
        up_if.valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_status("ar_now", 1'b0, 32'h0, 1'b1, 2'd0, 32'd0);
        tick(); tick();
        check_status("ar_held", 1'b0, 32'h0, 1'b1, 2'd0, 32'd0);
        rst_n = 1'b1;
        dn_if.ready = 1'b1;
        up_if.valid = 1'b1; up_if.data = 32'h55;
        tick(); check_status("ar_beat", 1'b1, 32'h55, 1'b1, 2'd1, 32'd0);
        up_if.valid = 1'b0;
        tick(); check_status("ar_end", 1'b0, 32'h0, 1'b1, 2'd0, 32'd0);

        tick();
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        check("beats_out", 32'(pop_cnt), 32'd6);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised successor to the fixed-field enable-gated pipeline registers between stages.
- Replaces the plain `en` hold with a valid/ready handshake and a 2-entry skid buffer. in_ready is a pure register output, so stage backpressure never forms a combinational path.
- Adds synchronous flush with bubble insertion, occupancy reporting and a saturating stall counter.
- Sits between any two pipeline stages (e.g. D->E); one instance carries the concatenated stage payload {instr, PC, operands, ext, flag}.

Parameters:
DATA_W, 32, payload width in bits (>=1)
BUBBLE_DATA, {DATA_W{1'b0}}, value driven on out_data when empty, and loaded on reset/flush (all-zero = NOP)
CNT_W, 16, stall counter width (>=1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
flush  input  1  synchronous flush; discards all held and incoming beats
in_valid  input  1  upstream beat valid
in_ready  output  1  stage can accept a beat; registered
in_data  input  DATA_W  upstream payload
out_valid  output  1  downstream beat valid
out_ready  input  1  downstream accepts
out_data  output  DATA_W  payload, equals BUBBLE_DATA when out_valid=0
occupancy  output  2  number of held beats, 0..2
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0; saturating

Behaviour:
- Handshakes:
  - acc = in_valid & in_ready
  - snd = out_valid & out_ready
  - Beats leave in arrival order; no beat is duplicated or dropped except by flush.
- Storage:
  - main register feeds out_data/out_valid.
  - skid register holds the overflow beat.
- States, encoded in the registered valid bits:
  - EMPTY (occ 0)
  - FULL (occ 1, main valid)
  - SKID (occ 2, both valid)
- Outputs:
  - in_ready = (state != SKID), decoded from registers only.
  - out_valid = (state != EMPTY).
- Transitions, evaluated on the clk rising edge when flush=0:
  - EMPTY: acc -> FULL, main<=in_data. Otherwise stay.
  - FULL, acc & snd: stay FULL, main<=in_data (full throughput, 1 beat/cycle).
  - FULL, acc & !snd: -> SKID, skid<=in_data, main held.
  - FULL, !acc & snd: -> EMPTY, main<=BUBBLE_DATA.
  - FULL, neither: hold.
  - SKID: acc is impossible because in_ready=0.
    - snd: -> FULL, main<=skid, skid<=BUBBLE_DATA.
    - Otherwise hold.
- Latency: a beat accepted in cycle N is visible on out_data in cycle N+1 when the stage was EMPTY, or when it was FULL with snd.
- Flush (synchronous, highest priority):
  - Next state is EMPTY; main and skid are loaded with BUBBLE_DATA.
  - A beat offered or sent in the same cycle is discarded. The upstream handshake still completes if in_ready=1; the beat is simply lost.
  - in_ready=1 from the next cycle.
  - stall_cnt is not affected by flush.
- Reset (reset=0, asynchronous, effective immediately, including mid-transfer):
  - state EMPTY; main=skid=BUBBLE_DATA.
  - out_valid=0, in_ready=1, occupancy=0, stall_cnt=0.
  - Registers stay in reset while reset=0. The first edge with reset=1 behaves as EMPTY.
- stall_cnt:
  - Increments by 1 each edge with out_valid=1 & out_ready=0 & flush=0.
  - Holds at 2^CNT_W-1 (no wrap).
  - Cleared only by reset.
- X-safety: with out_valid=0, out_data is exactly BUBBLE_DATA regardless of in_data.

Test Plan:
- Reset then idle. Release reset, in_valid=0 for 5 cycles -> out_valid=0, out_data=0, in_ready=1, occupancy=0, stall_cnt=0 every cycle.
- Streaming. out_ready=1, send in_data=0x100,0x104,0x108 on consecutive cycles -> out_data shows 0x100,0x104,0x108 on cycles N+1..N+3, in_ready stays 1, occupancy=1.
- Backpressure/skid. Hold out_ready=0 and send 0xA, 0xB -> occupancy 1 then 2, in_ready=0 after the second beat, stall_cnt increments each cycle. Raise out_ready -> out 0xA, then 0xB, then out_valid=0; in_ready returns to 1 the cycle after 0xA leaves.
- Flush in SKID with in_valid=1. Stage holds 0xA, 0xB, in_data=0xC, pulse flush 1 cycle -> next cycle occupancy=0, out_valid=0, out_data=BUBBLE_DATA, in_ready=1; 0xC never appears; stall_cnt unchanged.
- Saturation with CNT_W=3. out_valid=1, out_ready=0 for 12 cycles -> stall_cnt reaches 7 and holds at 7.
- Async reset mid-skid. Assert reset=0 between clock edges while occupancy=2 -> outputs go to reset values immediately, without waiting for an edge; after release, a new beat 0x55 passes with 1-cycle latency.
